ibex_pext_mmac_seq: RTL and testbench

Multi-cycle sequencer for the 32-bit P-extension "most-significant-word" multiply and multiply-accumulate ops (SMMUL, KMMAC, KMMSB and their rounding `u` variants). It sits directly downstream of the Pext control decoder in the EX stage. It consumes the decoded `signed_ops`, `width32` and `alu_sub` controls, plus the operands. Each op takes several cycles on a single 17x17 multiplier. The unit returns a saturated 32-bit result and an overflow flag to the ALU result mux and the `vxsat` update logic.

---
 rtl/ibex_pkg_pext.sv | 21 ++
 rtl/ibex_pext_mul17.sv | 11 +
 rtl/ibex_pext_mmac_seq.sv | 175 +++++++++++++++++
 tb/tb_ibex_pext_mmac_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg_pext.sv
// Shared types and constants for the P-extension MSW multiply/MAC sequencer.
// Optional rounding support is controlled by IBEX_PEXT_MMAC_ROUND_EN in the top module.
package ibex_pkg_pext;

    typedef enum logic [2:0] {
        PEXT_MMAC_IDLE   = 3'd0,
        PEXT_MMAC_MUL_LL = 3'd1,
        PEXT_MMAC_MUL_LH = 3'd2,
        PEXT_MMAC_MUL_HL = 3'd3,
        PEXT_MMAC_MUL_HH = 3'd4,
        PEXT_MMAC_DONE   = 3'd5
    } pext_mmac_state_e;

    localparam logic [31:0] PEXT_SMAX32 = 32'h7FFF_FFFF;
    localparam logic [31:0] PEXT_SMIN32 = 32'h8000_0000;
    localparam logic [31:0] PEXT_UMAX32 = 32'hFFFF_FFFF;

    // Half-LSB of the high word: preloading it makes acc[63:32] round-to-nearest.
    localparam logic [63:0] PEXT_MMAC_RND = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ibex_pext_mul17.sv
// Combinational signed 17x17 -> 34-bit multiplier, shared by all partial-product steps.
// Zero latency; no flow control.
module ibex_pext_mul17 (
    input  logic signed [16:0] a_i,
    input  logic signed [16:0] b_i,
    output logic signed [33:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/ibex_pext_mmac_seq.sv
// Multi-cycle MSW multiply / multiply-accumulate sequencer (SMMUL, KMMAC, KMMSB and rounding variants).
// Latency 5 cycles from en_i to valid_o; result held in DONE while ready_i is low; macro IBEX_PEXT_MMAC_ROUND_EN enables rounding.
module ibex_pext_mmac_seq
    import ibex_pkg_pext::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        ready_i,
    input  logic        signed_i,
    input  logic        width32_i,
    input  logic [1:0]  alu_sub_i,
    input  logic        accum_i,
    input  logic        round_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] op_c_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        ov_o,
    output logic        busy_o
);

    pext_mmac_state_e state_q, state_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      result_q, result_d;
    logic             ov_q, ov_d;

    logic [63:0]      preload;
    logic             unused_alu_sub;

    assign unused_alu_sub = alu_sub_i[1];

`ifdef IBEX_PEXT_MMAC_ROUND_EN
    assign preload = round_i ? PEXT_MMAC_RND : 64'd0;
`else
    logic unused_round;
    assign unused_round = round_i;
    assign preload      = 64'd0;
`endif

    // Operand halves: low halves are unsigned, high halves carry the sign when signed.
    logic signed [16:0] a_lo, a_hi, b_lo, b_hi;
    logic signed [16:0] mul_a, mul_b;
    logic signed [33:0] mul_p;
    logic [63:0]        pp_ext;
    logic [63:0]        pp_shifted;

    assign a_lo = {1'b0, op_a_i[15:0]};
    assign b_lo = {1'b0, op_b_i[15:0]};
    assign a_hi = {signed_i & op_a_i[31], op_a_i[31:16]};
    assign b_hi = {signed_i & op_b_i[31], op_b_i[31:16]};

    always_comb begin
        mul_a      = a_lo;
        mul_b      = b_lo;
        pp_shifted = pp_ext;
        unique case (state_q)
            PEXT_MMAC_MUL_LH: begin
                mul_b      = b_hi;
                pp_shifted = pp_ext << 16;
            end
            PEXT_MMAC_MUL_HL: begin
                mul_a      = a_hi;
                pp_shifted = pp_ext << 16;
            end
            PEXT_MMAC_MUL_HH: begin
                mul_a      = a_hi;
                mul_b      = b_hi;
                pp_shifted = pp_ext << 32;
            end
            default: ;
        endcase
    end

    ibex_pext_mul17 u_mul17 (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    assign pp_ext = {{30{mul_p[33]}}, mul_p};

    // Accumulate/saturate on the final accumulator value so DONE registers it directly.
    logic [31:0] prod_hi;
    logic [32:0] c_ext, p_ext, sum33;
    logic [31:0] sat_res;
    logic        sat_ov;

    assign prod_hi = acc_d[63:32];
    assign c_ext   = {signed_i & op_c_i[31], op_c_i};
    assign p_ext   = {signed_i & prod_hi[31], prod_hi};
    assign sum33   = alu_sub_i[0] ? (c_ext - p_ext) : (c_ext + p_ext);

    always_comb begin
        sat_res = sum33[31:0];
        sat_ov  = 1'b0;
        if (!accum_i) begin
            sat_res = prod_hi;
        end else if (signed_i) begin
            if (sum33[32] != sum33[31]) begin
                sat_ov  = 1'b1;
                sat_res = sum33[32] ? PEXT_SMIN32 : PEXT_SMAX32;
            end
        end else if (sum33[32]) begin
            // Unsigned: carry out on add saturates high, borrow on subtract saturates low.
            sat_ov  = 1'b1;
            sat_res = alu_sub_i[0] ? 32'd0 : PEXT_UMAX32;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        ov_d     = ov_q;
        unique case (state_q)
            PEXT_MMAC_IDLE: begin
                result_d = 32'd0;
                ov_d     = 1'b0;
                if (en_i && width32_i) begin
                    acc_d   = preload;
                    state_d = PEXT_MMAC_MUL_LL;
                end
            end
            PEXT_MMAC_MUL_LL,
            PEXT_MMAC_MUL_LH,
            PEXT_MMAC_MUL_HL,
            PEXT_MMAC_MUL_HH: begin
                acc_d = acc_q + pp_shifted;
                if (!en_i) begin
                    state_d = PEXT_MMAC_IDLE;
                end else if (state_q == PEXT_MMAC_MUL_HH) begin
                    state_d  = PEXT_MMAC_DONE;
                    result_d = sat_res;
                    ov_d     = sat_ov;
                end else begin
                    state_d = pext_mmac_state_e'(state_q + 3'd1);
                end
            end
            PEXT_MMAC_DONE: begin
                if (ready_i || !en_i) begin
                    state_d  = PEXT_MMAC_IDLE;
                    result_d = 32'd0;
                    ov_d     = 1'b0;
                end
            end
            default: begin
                state_d  = PEXT_MMAC_IDLE;
                result_d = 32'd0;
                ov_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= PEXT_MMAC_IDLE;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ov_q     <= ov_d;
        end
    end

    assign result_o = result_q;
    assign ov_o     = ov_q;
    assign valid_o  = (state_q == PEXT_MMAC_DONE);
    assign busy_o   = (state_q != PEXT_MMAC_IDLE);

endmodule

// File: tb/tb_ibex_pext_mmac_seq.sv
// Directed bench for ibex_pext_mmac_seq: products, saturation, rounding, kill, backpressure, reset.
module tb_ibex_pext_mmac_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        signed_i = 1'b0;
    logic        width32_i = 1'b1;
    logic [1:0]  alu_sub_i = 2'b00;
    logic        accum_i = 1'b0;
    logic        round_i = 1'b0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic [31:0] op_c_i = '0;
    logic [31:0] result_o;
    logic        valid_o;
    logic        ov_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    ibex_pext_mmac_seq dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .ready_i   (ready_i),
        .signed_i  (signed_i),
        .width32_i (width32_i),
        .alu_sub_i (alu_sub_i),
        .accum_i   (accum_i),
        .round_i   (round_i),
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .op_c_i    (op_c_i),
        .result_o  (result_o),
        .valid_o   (valid_o),
        .ov_o      (ov_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input logic s, input logic acc, input logic [1:0] sub, input logic rnd,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        signed_i  = s;
        accum_i   = acc;
        alu_sub_i = sub;
        round_i   = rnd;
        op_a_i    = a;
        op_b_i    = b;
        op_c_i    = c;
        en_i      = 1'b1;
    endtask

    // Returns the number of edges until valid_o is seen; 99 if it never rises.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (valid_o) break;
        end
        if (!valid_o) lat = 99;
    endtask

    task automatic run_op(input string tag, input logic s, input logic acc, input logic [1:0] sub,
                          input logic rnd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] exp_res, input logic exp_ov);
        int lat;
        start_op(s, acc, sub, rnd, a, b, c);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 32'd5);
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_ov"}, {31'd0, ov_o}, {31'd0, exp_ov});
        en_i = 1'b0;
        tick();
        check({tag, "_idle_vld"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        logic        seen_vld;

        #12;
        check("rst_vld", {31'd0, valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_res", result_o, 32'd0);
        check("rst_ov", {31'd0, ov_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        run_op("smul",    1'b1, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h1000_0000, 1'b0);
        run_op("psat",    1'b1, 1'b1, 2'b00, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        run_op("nsat",    1'b1, 1'b1, 2'b11, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op("umul",    1'b0, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 1'b0);
        run_op("sneg",    1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'hFFFF_FFFF, 1'b0);
        run_op("smac",    1'b1, 1'b1, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0000_0005, 32'h1000_0005, 1'b0);
        run_op("umac_hi", 1'b0, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
        run_op("umsb_lo", 1'b0, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
`ifdef IBEX_PEXT_MMAC_ROUND_EN
        run_op("round",   1'b1, 1'b0, 2'b00, 1'b1, 32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0000_0001, 1'b0);
`else
        run_op("round",   1'b1, 1'b0, 2'b00, 1'b1, 32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0000_0000, 1'b0);
`endif

        // width32_i low: request ignored
        width32_i = 1'b0;
        start_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
        tick();
        tick();
        check("w16_busy", {31'd0, busy_o}, 32'd0);
        en_i = 1'b0;
        width32_i = 1'b1;
        tick();

        // Kill: en_i dropped in cycle 2
        start_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
        tick();
        tick();
        check("kill_busy_c2", {31'd0, busy_o}, 32'd1);
        en_i = 1'b0;
        tick();
        check("kill_busy_c3", {31'd0, busy_o}, 32'd0);
        seen_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_vld = seen_vld | valid_o;
        end
        check("kill_no_vld", {31'd0, seen_vld}, 32'd0);
        run_op("after_kill", 1'b1, 1'b1, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0000_0005, 32'h1000_0005, 1'b0);

        // Backpressure: ready_i low for 3 cycles in DONE
        ready_i = 1'b0;
        start_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
        wait_valid(lat);
        check("bp_lat", lat, 32'd5);
        held = result_o;
        check("bp_res", held, 32'h1000_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_vld", {31'd0, valid_o}, 32'd1);
            check("bp_hold_res", result_o, 32'h1000_0000);
        end
        ready_i = 1'b1;
        tick();
        check("bp_rel_vld", {31'd0, valid_o}, 32'd0);
        check("bp_rel_busy", {31'd0, busy_o}, 32'd0);
        check("bp_rel_res", result_o, 32'd0);
        en_i = 1'b0;
        tick();

        // Asynchronous reset mid-op
        start_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0);
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        en_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        seen_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_vld = seen_vld | valid_o;
        end
        check("arst_no_vld", {31'd0, seen_vld}, 32'd0);
        run_op("after_rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h1000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
